// File: rtl/inst_axi_rd_bridge_pkg.sv
// Shared AXI read-side constants and the AR channel state type for the
// instruction-fetch read bridge.
package inst_axi_rd_bridge_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [2:0] SIZE_WORD    = 3'd2;
  localparam logic [7:0] ARLEN_SINGLE = 8'd0;

  typedef enum logic {
    IDLE    = 1'b0,
    AR_WAIT = 1'b1
  } ar_state_t;

endpackage

// File: rtl/inst_axi_rd_bridge.sv
// Turns fetch-stage sram-like requests into single-beat AXI4 reads, keeping
// up to MAX_OUTSTANDING reads in flight and returning data in issue order.
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int         MAX_OUTSTANDING = 2,
  parameter logic [3:0] ARID_VAL        = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

  ar_state_t   state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] araddr_reg;
  logic [2:0]  arsize_reg;
  logic        full;
  logic        unused_ok;

  // Write-side and response-status inputs have no meaning on a read-only,
  // single-ID, single-beat port.
  assign unused_ok = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rid, rresp, rlast};

  assign rready            = (cnt_reg != 2'd0);
  assign inst_sram_data_ok = rvalid && rready;
  assign inst_sram_rdata   = rdata;

  // A response retiring in this cycle frees the slot a new request needs.
  assign full = (cnt_reg == MAX_CNT) && !inst_sram_data_ok;

  assign inst_sram_addr_ok = resetn && inst_sram_req && !full &&
                             ((state_reg == IDLE) || arready);

  assign arid    = ARID_VAL;
  assign araddr  = araddr_reg;
  assign arlen   = ARLEN_SINGLE;
  assign arsize  = arsize_reg;
  assign arburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  always_comb begin
    state_next = state_reg;
    arvalid    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (inst_sram_addr_ok) state_next = AR_WAIT;
      end
      AR_WAIT: begin
        arvalid = 1'b1;
        if (inst_sram_addr_ok) state_next = AR_WAIT;
        else if (arready)      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_next = cnt_reg;
    case ({inst_sram_addr_ok, inst_sram_data_ok})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg  <= IDLE;
      cnt_reg    <= 2'd0;
      araddr_reg <= 32'd0;
      arsize_reg <= SIZE_WORD;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (inst_sram_addr_ok) begin
        araddr_reg <= inst_sram_addr;
        arsize_reg <= {1'b0, inst_sram_size};
      end
    end
  end

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Self-checking bench for inst_axi_rd_bridge: directed scenarios followed by
// randomized traffic against a queue-based transaction model.
module tb_inst_axi_rd_bridge;

  localparam int MAX = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] inst_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inst_axi_rd_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(4'd0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
    .inst_sram_wstrb(wstrb), .inst_sram_addr(addr), .inst_sram_wdata(wdata),
    .inst_sram_addr_ok(addr_ok), .inst_sram_data_ok(data_ok),
    .inst_sram_rdata(inst_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F1E_2D3C;
  endfunction

  task automatic test_reset;
    resetn = 1'b0; req = 1'b1; addr = 32'h1234_5678; rvalid = 1'b1; arready = 1'b1;
    next_cycle; next_cycle; #1;
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got=%0b exp=0", arvalid); end
    checks++; if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok got=%0b exp=0", addr_ok); end
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL reset_rready got=%0b exp=0", rready); end
    checks++; if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok got=%0b exp=0", data_ok); end
    checks++; if (araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr got=%h exp=0", araddr); end
    checks++; if (arsize !== 3'd2) begin errors++; $display("FAIL reset_arsize got=%0d exp=2", arsize); end
    resetn = 1'b1; req = 1'b0; rvalid = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_single_read;
    next_cycle; req = 1'b1; addr = 32'h1c00_0000; arready = 1'b1; rvalid = 1'b0; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL single_addr_ok got=%0b exp=1", addr_ok); end
    next_cycle; req = 1'b0; #1;
    checks++; if (arvalid !== 1'b1) begin errors++; $display("FAIL single_arvalid got=%0b exp=1", arvalid); end
    checks++; if (araddr !== 32'h1c00_0000) begin errors++; $display("FAIL single_araddr got=%h exp=1c000000", araddr); end
    checks++; if (arsize !== 3'd2 || arlen !== 8'd0 || arburst !== 2'b01 || arid !== 4'd0)
      begin errors++; $display("FAIL single_arfields got=size%0d len%0d burst%0d id%0d exp=2/0/1/0", arsize, arlen, arburst, arid); end
    next_cycle; rvalid = 1'b1; rdata = 32'h0280_0000; #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL single_data_ok got=%0b exp=1", data_ok); end
    checks++; if (inst_rdata !== 32'h0280_0000) begin errors++; $display("FAIL single_rdata got=%h exp=02800000", inst_rdata); end
    checks++; if (arvalid !== 1'b0) begin errors++; $display("FAIL single_arvalid_drop got=%0b exp=0", arvalid); end
    next_cycle; rvalid = 1'b0; #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL single_rready_idle got=%0b exp=0", rready); end
    $display("test_single_read done");
  endtask

  task automatic test_back_to_back;
    logic [31:0] base = 32'h1c00_0000;
    arready = 1'b1; rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle; req = 1'b1; addr = base + 32'(4 * i); #1;
      checks++; if (addr_ok !== (i < 2)) begin errors++; $display("FAIL b2b_addr_ok%0d got=%0b exp=%0b", i, addr_ok, (i < 2)); end
    end
    checks++; if (araddr !== base + 32'd4 || rready !== 1'b1)
      begin errors++; $display("FAIL b2b_second_ar got=%h/%0b exp=%h/1", araddr, rready, base + 32'd4); end
    next_cycle; addr = base + 32'd8; rvalid = 1'b1; rdata = mem_word(base); #1;
    checks++; if (addr_ok !== 1'b1 || data_ok !== 1'b1)
      begin errors++; $display("FAIL b2b_full_rvalid got=aok%0b dok%0b exp=1/1", addr_ok, data_ok); end
    next_cycle; req = 1'b0; rdata = mem_word(base + 32'd4); #1;
    checks++; if (arvalid !== 1'b1 || araddr !== base + 32'd8 || data_ok !== 1'b1)
      begin errors++; $display("FAIL b2b_third_ar got=%0b/%h/%0b exp=1/%h/1", arvalid, araddr, data_ok, base + 32'd8); end
    next_cycle; rdata = mem_word(base + 32'd8); #1;
    checks++; if (data_ok !== 1'b1 || arvalid !== 1'b0)
      begin errors++; $display("FAIL b2b_last_resp got=dok%0b arv%0b exp=1/0", data_ok, arvalid); end
    next_cycle; rvalid = 1'b0; #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0b exp=0", rready); end
    $display("test_back_to_back done");
  endtask

  task automatic test_ar_backpressure;
    logic [31:0] a = 32'h1c00_0100;
    logic [31:0] b = 32'h1c00_0104;
    arready = 1'b0; rvalid = 1'b0;
    next_cycle; req = 1'b1; addr = a; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL bp_first_aok got=%0b exp=1", addr_ok); end
    for (int i = 0; i < 3; i++) begin
      next_cycle; addr = b; #1;
      checks++; if (arvalid !== 1'b1 || araddr !== a || addr_ok !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d got=%0b/%h/%0b exp=1/%h/0", i, arvalid, araddr, addr_ok, a); end
    end
    next_cycle; arready = 1'b1; #1;
    checks++; if (addr_ok !== 1'b1 || araddr !== a) begin errors++; $display("FAIL bp_release got=%0b/%h exp=1/%h", addr_ok, araddr, a); end
    next_cycle; req = 1'b0; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== b) begin errors++; $display("FAIL bp_second_ar got=%0b/%h exp=1/%h", arvalid, araddr, b); end
    next_cycle; rvalid = 1'b1; rdata = mem_word(a); #1;
    checks++; if (arvalid !== 1'b0 || data_ok !== 1'b1) begin errors++; $display("FAIL bp_resp_a got=%0b/%0b exp=0/1", arvalid, data_ok); end
    next_cycle; rdata = mem_word(b); #1;
    checks++; if (data_ok !== 1'b1) begin errors++; $display("FAIL bp_resp_b got=%0b exp=1", data_ok); end
    next_cycle; rvalid = 1'b0; #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL bp_drained got=%0b exp=0", rready); end
    $display("test_ar_backpressure done");
  endtask

  task automatic test_in_order;
    logic [31:0] beats [2] = '{32'hAAAA_AAAA, 32'hBBBB_BBBB};
    arready = 1'b1; rvalid = 1'b0;
    next_cycle; req = 1'b1; addr = 32'h1c00_0200;
    next_cycle; addr = 32'h1c00_0204;
    next_cycle; req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      next_cycle; rvalid = 1'b1; rdata = beats[i]; #1;
      checks++; if (data_ok !== 1'b1 || inst_rdata !== beats[i])
        begin errors++; $display("FAIL inorder_beat%0d got=%0b/%h exp=1/%h", i, data_ok, inst_rdata, beats[i]); end
    end
    next_cycle; rvalid = 1'b0; #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL inorder_cnt_zero got=rready%0b exp=0", rready); end
    $display("test_in_order done");
  endtask

  task automatic test_stray_rvalid;
    req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle; rvalid = 1'b1; rdata = $urandom(); #1;
      checks++; if (rready !== 1'b0 || data_ok !== 1'b0)
        begin errors++; $display("FAIL stray%0d got=rready%0b dok%0b exp=0/0", i, rready, data_ok); end
    end
    rvalid = 1'b0;
    $display("test_stray_rvalid done");
  endtask

  task automatic test_reset_midflight;
    arready = 1'b0; rvalid = 1'b0;
    next_cycle; req = 1'b1; addr = 32'h1c00_0300; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL midrst_issue got=%0b exp=1", addr_ok); end
    next_cycle; resetn = 1'b0; #1;
    checks++; if (addr_ok !== 1'b0 || arvalid !== 1'b1)
      begin errors++; $display("FAIL midrst_during got=aok%0b arv%0b exp=0/1", addr_ok, arvalid); end
    next_cycle; #1;
    checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || addr_ok !== 1'b0)
      begin errors++; $display("FAIL midrst_after got=arv%0b rdy%0b aok%0b exp=0/0/0", arvalid, rready, addr_ok); end
    resetn = 1'b1; req = 1'b0; arready = 1'b1;
    next_cycle; req = 1'b1; addr = 32'h1c00_0400; #1;
    checks++; if (addr_ok !== 1'b1) begin errors++; $display("FAIL midrst_resume_aok got=%0b exp=1", addr_ok); end
    next_cycle; req = 1'b0; #1;
    checks++; if (arvalid !== 1'b1 || araddr !== 32'h1c00_0400)
      begin errors++; $display("FAIL midrst_resume_ar got=%0b/%h exp=1/1c000400", arvalid, araddr); end
    next_cycle; rvalid = 1'b1; rdata = 32'h1357_9bdf; #1;
    checks++; if (data_ok !== 1'b1 || inst_rdata !== 32'h1357_9bdf)
      begin errors++; $display("FAIL midrst_resume_data got=%0b/%h exp=1/13579bdf", data_ok, inst_rdata); end
    next_cycle; rvalid = 1'b0; #1;
    checks++; if (rready !== 1'b0) begin errors++; $display("FAIL midrst_drained got=%0b exp=0", rready); end
    $display("test_reset_midflight done");
  endtask

  // Model: accepted-not-yet-issued addresses, accepted-not-yet-returned
  // addresses (issue order), and the slave's queue of received AR addresses.
  task automatic test_random;
    logic [31:0] ar_pend [$];
    logic [31:0] ret_q [$];
    logic [31:0] slv_q [$];
    logic exp_dok, exp_full, exp_aok;
    int cyc_err = 0;
    for (int n = 0; n < 600; n++) begin
      bit draining;
      draining = (n >= 500);
      next_cycle;
      req     = !draining && ($urandom_range(0, 9) < 7);
      addr    = $urandom() & ~32'h3;
      arready = draining || ($urandom_range(0, 9) < 6);
      if (slv_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        rvalid = 1'b1; rdata = mem_word(slv_q[0]);
      end else if (ret_q.size() == 0 && $urandom_range(0, 7) == 0) begin
        rvalid = 1'b1; rdata = $urandom();
      end else begin
        rvalid = 1'b0;
      end
      #1;
      exp_dok  = rvalid && (ret_q.size() > 0);
      exp_full = (ret_q.size() == MAX) && !exp_dok;
      exp_aok  = req && !exp_full && (ar_pend.size() == 0 || arready);
      checks++; if (addr_ok !== exp_aok) begin errors++; cyc_err++; $display("FAIL rnd_addr_ok cyc=%0d got=%0b exp=%0b", n, addr_ok, exp_aok); end
      checks++; if (data_ok !== exp_dok) begin errors++; cyc_err++; $display("FAIL rnd_data_ok cyc=%0d got=%0b exp=%0b", n, data_ok, exp_dok); end
      checks++; if (rready !== (ret_q.size() > 0)) begin errors++; cyc_err++; $display("FAIL rnd_rready cyc=%0d got=%0b exp=%0b", n, rready, ret_q.size() > 0); end
      checks++; if (arvalid !== (ar_pend.size() > 0)) begin errors++; cyc_err++; $display("FAIL rnd_arvalid cyc=%0d got=%0b exp=%0b", n, arvalid, ar_pend.size() > 0); end
      if (ar_pend.size() > 0) begin
        checks++; if (araddr !== ar_pend[0]) begin errors++; cyc_err++; $display("FAIL rnd_araddr cyc=%0d got=%h exp=%h", n, araddr, ar_pend[0]); end
      end
      if (exp_dok) begin
        checks++; if (inst_rdata !== mem_word(ret_q[0])) begin errors++; cyc_err++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", n, inst_rdata, mem_word(ret_q[0])); end
      end
      if (ar_pend.size() > 0 && arready) slv_q.push_back(ar_pend.pop_front());
      if (exp_aok) begin ar_pend.push_back(addr); ret_q.push_back(addr); end
      if (exp_dok) begin
        void'(ret_q.pop_front());
        if (slv_q.size() > 0) void'(slv_q.pop_front());
      end
    end
    next_cycle; req = 1'b0; rvalid = 1'b0; #1;
    checks++; if (rready !== (ret_q.size() > 0) || ret_q.size() != 0)
      begin errors++; $display("FAIL rnd_final_drain got=rready%0b pending=%0d exp=0/0", rready, ret_q.size()); end
    $display("test_random done cycle_errors=%0d", cyc_err);
  endtask

  initial begin
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'h2; wstrb = 4'h0;
    addr = 32'd0; wdata = 32'd0; arready = 1'b0; rid = 4'd0; rdata = 32'd0;
    rresp = 2'd0; rlast = 1'b1; rvalid = 1'b0;
    test_reset;
    test_single_read;
    test_back_to_back;
    test_ar_backpressure;
    test_in_order;
    test_stray_rvalid;
    test_reset_midflight;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
